// File: rtl/midi_note_scheduler.sv
// midi_note_scheduler: key vector to MIDI Note On/Off byte stream.
// One 3-byte message at a time, lowest changed key first.
module midi_note_scheduler #(
  parameter int NUM_KEYS  = 10,
  parameter int BASE_NOTE = 60,
  parameter int CHANNEL   = 0,
  parameter int VELOCITY  = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [NUM_KEYS-1:0] key,
  input  logic [4:0]          pitchshift,
  input  logic                tx_ready,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic [NUM_KEYS-1:0] sounding
);

  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [7:0] CH     = 8'(CHANNEL % 16);
  localparam logic [7:0] ST_ON  = 8'h90 | CH;
  localparam logic [7:0] ST_OFF = 8'h80 | CH;
  localparam logic [7:0] VEL_B  = 8'(VELOCITY);

  typedef enum logic [1:0] {
    IDLE,
    STATUS,
    NOTE,
    VEL
  } state_t;

  state_t state, state_nx;

  logic [NUM_KEYS-1:0] target, change;
  logic [IW-1:0]       idx, sel;
  logic                dir;
  logic [6:0]          nn, nn_on;
  logic [6:0]          note_mem [NUM_KEYS];
  logic signed [8:0]   sum;
  logic                hs, valid_nx;
  logic [7:0]          data_nx;

  assign target = ena ? key : '0;
  assign change = target ^ sounding;
  assign hs     = tx_valid && tx_ready;
  assign busy   = (state != IDLE);

  // Lowest changed key and its clamped note number at current pitch.
  always_comb begin
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (change[i]) idx = IW'(i);
    end
    sum = 9'(BASE_NOTE) + 9'(idx)
        + {{4{pitchshift[4]}}, pitchshift};
    if (sum[8])             nn_on = 7'd0;
    else if (sum > 9'sd127) nn_on = 7'd127;
    else                    nn_on = sum[6:0];
  end

  // Next state and next registered byte-stream outputs.
  always_comb begin
    state_nx = state;
    valid_nx = tx_valid;
    data_nx  = tx_data;
    unique case (state)
      IDLE: begin
        valid_nx = 1'b0;
        if (change != '0) begin
          state_nx = STATUS;
          valid_nx = 1'b1;
          data_nx  = target[idx] ? ST_ON : ST_OFF;
        end
      end
      STATUS: begin
        if (hs) begin
          state_nx = NOTE;
          data_nx  = {1'b0, nn};
        end
      end
      NOTE: begin
        if (hs) begin
          state_nx = VEL;
          data_nx  = dir ? VEL_B : 8'h00;
        end
      end
      VEL: begin
        if (hs) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
          data_nx  = 8'h00;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, outputs, message latch and per-key note memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      sounding <= '0;
      sel      <= '0;
      dir      <= 1'b0;
      nn       <= '0;
      for (int i = 0; i < NUM_KEYS; i++) note_mem[i] <= '0;
    end else begin
      state    <= state_nx;
      tx_valid <= valid_nx;
      tx_data  <= data_nx;
      if (state == IDLE && change != '0) begin
        sel <= idx;
        dir <= target[idx];
        if (target[idx]) begin
          nn            <= nn_on;
          note_mem[idx] <= nn_on;
        end else begin
          nn <= note_mem[idx];
        end
      end
      if (state == VEL && hs) sounding[sel] <= ~sounding[sel];
    end
  end

endmodule

// File: tb/tb_midi_note_scheduler.sv
// tb_midi_note_scheduler: directed vectors for midi_note_scheduler.
// Second instance uses BASE_NOTE = 120 for the high clamp.
module tb_midi_note_scheduler;

  logic       clk = 0;
  logic       rst_n;
  logic       ena, ena_hi;
  logic [9:0] key, key_hi;
  logic [4:0] ps, ps_hi;
  logic       tx_ready;
  logic       tx_valid, hi_valid;
  logic [7:0] tx_data, hi_data;
  logic       busy, hi_busy;
  logic [9:0] sounding, hi_sounding;

  int  n_run = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  t1, t2, t_first;
  logic use_hi = 0;

  logic       m_valid;
  logic [7:0] m_data;
  assign m_valid = use_hi ? hi_valid : tx_valid;
  assign m_data  = use_hi ? hi_data : tx_data;

  midi_note_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .key(key),
    .pitchshift(ps), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .busy(busy), .sounding(sounding)
  );

  midi_note_scheduler #(.BASE_NOTE(120)) u_hi (
    .clk(clk), .rst_n(rst_n), .ena(ena_hi), .key(key_hi),
    .pitchshift(ps_hi), .tx_ready(tx_ready),
    .tx_valid(hi_valid), .tx_data(hi_data),
    .busy(hi_busy), .sounding(hi_sounding)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic msg(string tag, logic [7:0] b0,
                     logic [7:0] b1, logic [7:0] b2);
    int n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " valid"}, 32'(m_valid), 32'd1);
    t_first = cyc;
    chk({tag, " status"}, 32'(m_data), 32'(b0));
    @(negedge clk);
    chk({tag, " note"}, 32'(m_data), 32'(b1));
    @(negedge clk);
    chk({tag, " vel"}, 32'(m_data), 32'(b2));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; ena = 1; ena_hi = 1;
    key = 0; key_hi = 0; ps = 0; ps_hi = 0;
    tx_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst valid", 32'(tx_valid), 32'd0);
    chk("rst data", 32'(tx_data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst sounding", 32'(sounding), 32'd0);
    rst_n = 1;
    @(negedge clk);

    key = 10'h001;
    msg("k0 on", 8'h90, 8'h3C, 8'h64);
    chk("k0 sounding", 32'(sounding), 32'h001);
    key = 10'h000;
    msg("k0 off", 8'h80, 8'h3C, 8'h00);
    chk("k0 off sounding", 32'(sounding), 32'h000);

    key = 10'h011;
    msg("sim k0", 8'h90, 8'h3C, 8'h64);
    t1 = t_first;
    msg("sim k4", 8'h90, 8'h40, 8'h64);
    t2 = t_first;
    chk("sim gap", 32'(t2 - t1), 32'd4);
    chk("sim sounding", 32'(sounding), 32'h011);
    key = 10'h000;
    msg("rel k0", 8'h80, 8'h3C, 8'h00);
    msg("rel k4", 8'h80, 8'h40, 8'h00);

    tx_ready = 0;
    key = 10'h004;
    for (int n = 0; n < 20 && !tx_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", 32'(tx_valid), 32'd1);
      chk("bp data", 32'(tx_data), 32'h90);
      @(negedge clk);
    end
    tx_ready = 1;
    msg("bp k2", 8'h90, 8'h3E, 8'h64);
    key = 10'h000;
    msg("bp k2 off", 8'h80, 8'h3E, 8'h00);

    ps = 5'd2;
    key = 10'h001;
    msg("ps on", 8'h90, 8'h3E, 8'h64);
    ps = 5'b11011;
    key = 10'h000;
    msg("ps off", 8'h80, 8'h3E, 8'h00);
    ps = 0;

    use_hi = 1;
    ps_hi = 5'd15;
    key_hi = 10'h200;
    msg("clamp", 8'h90, 8'h7F, 8'h64);
    chk("clamp sounding", 32'(hi_sounding), 32'h200);
    use_hi = 0;

    key = 10'h00A;
    msg("fl k1 on", 8'h90, 8'h3D, 8'h64);
    msg("fl k3 on", 8'h90, 8'h3F, 8'h64);
    chk("fl sounding", 32'(sounding), 32'h00A);
    ena = 0;
    msg("fl k1 off", 8'h80, 8'h3D, 8'h00);
    msg("fl k3 off", 8'h80, 8'h3F, 8'h00);
    chk("fl cleared", 32'(sounding), 32'h000);
    for (int i = 0; i < 6; i++) begin
      chk("fl quiet", 32'(tx_valid), 32'd0);
      @(negedge clk);
    end
    ena = 1;
    msg("re k1 on", 8'h90, 8'h3D, 8'h64);
    msg("re k3 on", 8'h90, 8'h3F, 8'h64);
    key = 10'h008;
    msg("k1 off", 8'h80, 8'h3D, 8'h00);
    chk("only k3", 32'(sounding), 32'h008);

    key = 10'h009;
    for (int n = 0; n < 20 && !tx_valid; n++) @(negedge clk);
    chk("mr status", 32'(tx_data), 32'h90);
    @(negedge clk);
    chk("mr note", 32'(tx_data), 32'h3C);
    rst_n = 0;
    #1;
    chk("mr valid", 32'(tx_valid), 32'd0);
    chk("mr sounding", 32'(sounding), 32'h000);
    chk("mr busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1;
    msg("mr k0", 8'h90, 8'h3C, 8'h64);
    msg("mr k3", 8'h90, 8'h3F, 8'h64);
    chk("mr final", 32'(sounding), 32'h009);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_note_scheduler.md
Name: midi_note_scheduler

Overview:
- Converts the debounced 10-key one-hot/polyphonic key vector into a serialized MIDI Note On/Note Off byte stream, one 3-byte message at a time.
- Sits between modeselect (Note, Pitchshift) and the UART transmitter inside the midi path.
- Arbitrates simultaneous key changes by fixed priority and remembers the transmitted note number per key, so pitch changes never orphan a note.
- Flushes all sounding notes when disabled.

Parameters:
- NUM_KEYS, 10, number of key inputs.
- BASE_NOTE, 60, MIDI note number of key 0 at zero pitchshift.
- CHANNEL, 0, MIDI channel (0-15) placed in the status low nibble.
- VELOCITY, 100, velocity byte for Note On (1-127).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  MIDI output enable (ena_midi)
- key  in  NUM_KEYS  debounced key state, bit i high = key i held
- pitchshift  in  5  signed two's-complement semitone offset, -16..+15
- tx_ready  in  1  UART can accept a byte this cycle
- tx_valid  out  1  tx_data is valid
- tx_data  out  8  MIDI byte
- busy  out  1  message in progress (state != IDLE)
- sounding  out  NUM_KEYS  keys for which Note On has been sent and no Note Off yet

Behaviour:
- Reset (async, rst_n low): state IDLE, tx_valid 0, tx_data 0x00, busy 0, sounding 0, all stored note numbers 0.
- target = ena ? key : 0. change = target XOR sounding.
- FSM states: IDLE, STATUS, NOTE, VEL.
- IDLE:
  - If change != 0, select the lowest set index i and latch sel = i and dir = target[i] (1 = on, 0 = off).
  - Note On: compute nn = clamp(BASE_NOTE + i + sext(pitchshift), 0, 127) in 9-bit signed arithmetic, and store it in note_mem[i].
  - Note Off: nn = note_mem[i]. The current pitchshift is ignored.
  - Next state STATUS. Otherwise stay in IDLE.
- STATUS: tx_valid = 1, tx_data = (dir ? 0x90 : 0x80) | CHANNEL. Advance to NOTE on tx_valid && tx_ready.
- NOTE: tx_data = {1'b0, nn[6:0]}. Advance to VEL on handshake.
- VEL: tx_data = dir ? VELOCITY : 0x00. On handshake, toggle sounding[sel] and go to IDLE.
- tx_valid and tx_data are registered outputs. Both are held stable while tx_valid && !tx_ready, and tx_valid is 0 in IDLE.
- Latency:
  - First byte is valid the cycle after IDLE sees change != 0.
  - With tx_ready held high, a message takes 3 cycles, plus 1 IDLE cycle before the next message. Minimum message period is 4 cycles.
- No running status. Every message carries its status byte.
- Key, ena and pitchshift changes during a message do not alter that message. They are re-evaluated at the next IDLE.
  - A press followed by release mid-message yields a completed On, then an Off.
- Simultaneous changes are served lowest index first, one per IDLE visit. A press and a release are treated equally.
- ena deassert: the in-flight message completes, then Note Offs are issued for every sounding key, lowest index first. No Note On is issued while ena = 0.
- The clamp guarantees the NOTE byte has bit 7 = 0.
- Mid-operation reset: tx_valid drops immediately and the partial message is abandoned. The downstream UART must share rst_n.

Test Plan:
- Single key, tx_ready = 1, ps = 0: key = 10'h001 → bytes 0x90, 0x3C, 0x64 and sounding = 10'h001. Then key = 0 → 0x80, 0x3C, 0x00 and sounding = 0.
- Simultaneous press: key 0 -> 10'h011 → message for key0 (0x90, 0x3C, 0x64) then key4 (0x90, 0x40, 0x64). Exactly 4 cycles separate the two first-byte handshakes.
- Backpressure: press key2 with tx_ready low for 5 cycles → tx_valid = 1 and tx_data = 0x90 stable for all 5 cycles. Then 0x90, 0x3E, 0x64 are accepted in order.
- Pitch latch and clamp:
  - Press key0 at ps = +2 → note 0x3E. Set ps = -5, release → Note Off uses 0x3E.
  - With BASE_NOTE = 120, key9 at ps = +15 → note byte 0x7F.
- ena flush: keys 1 and 3 sounding, drop ena → 0x80, 0x3D, 0x00 then 0x80, 0x3F, 0x00 and sounding = 0. Keys still held produce no output until ena returns.
- Reset mid-message: assert rst_n low during NOTE → tx_valid = 0 and sounding = 0 asynchronously. After release with key held → a fresh 0x90 message.
